// File: rtl/pc_stack_unit.sv
// pc_stack_unit - program counter with a circular hardware return stack for instruction fetch.
module pc_stack_unit #(
  parameter int                ADDR_W    = 11,
  parameter int                DEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [2:0]                 pc_op,
  input  logic [ADDR_W-1:0]          target,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]     stack_level,
  output logic [ADDR_W-1:0]          top,
  output logic                       ovf,
  output logic                       unf
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int LVL_W = SP_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_NEXT   = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RETURN = 3'd4
  } op_e;

  logic [ADDR_W-1:0] r_stack [DEPTH];
  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [SP_W-1:0]   w_sp_dec;
  logic [ADDR_W-1:0] w_top;

  assign w_pc_inc = r_pc + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;
  assign w_top    = (r_level == '0) ? RESET_VEC : r_stack[w_sp_dec];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_VEC;
      r_sp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      // A flag event later in this block overrides the clear, so set wins.
      if (clr_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (!stall) begin
        case (pc_op)
          OP_HOLD: ;
          OP_JUMP: r_pc <= target;
          OP_CALL: begin
            r_stack[r_sp] <= w_pc_inc;
            r_sp          <= r_sp + 1'b1;
            r_pc          <= target;
            if (r_level == FULL_LVL) begin
              r_ovf <= 1'b1;
            end else begin
              r_level <= r_level + 1'b1;
            end
          end
          OP_RETURN: begin
            if (r_level == '0) begin
              r_pc  <= RESET_VEC;
              r_unf <= 1'b1;
            end else begin
              r_pc    <= w_top;
              r_sp    <= w_sp_dec;
              r_level <= r_level - 1'b1;
            end
          end
          default: r_pc <= w_pc_inc;
        endcase
      end
    end
  end

  assign pc          = r_pc;
  assign stack_level = r_level;
  assign top         = w_top;
  assign ovf         = r_ovf;
  assign unf         = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit.
module tb_pc_stack_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_op;
  logic [10:0] target;
  logic        clr_err;
  logic [10:0] pc;
  logic [3:0]  stack_level;
  logic [10:0] top;
  logic        ovf;
  logic        unf;

  int total;
  int bad;

  pc_stack_unit #(.ADDR_W(11), .DEPTH(8), .RESET_VEC(11'h000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .target(target),
    .clr_err(clr_err), .pc(pc), .stack_level(stack_level), .top(top),
    .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [10:0] tgt);
    pc_op  = op;
    target = tgt;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; pc_op = 3'd1; target = '0; clr_err = 1'b0;
    repeat (3) step();
    total++; if (pc !== 11'h000) begin $display("FAIL reset_pc got=%h exp=000", pc); bad++; end
    total++; if (stack_level !== 4'd0) begin $display("FAIL reset_level got=%0d exp=0", stack_level); bad++; end
    total++; if ({ovf, unf} !== 2'b00) begin $display("FAIL reset_flags got=%b exp=00", {ovf, unf}); bad++; end
    total++; if (top !== 11'h000) begin $display("FAIL reset_top got=%h exp=000", top); bad++; end
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(3'd1, '0);
      total++; if (pc !== 11'(i)) begin $display("FAIL next_pc[%0d] got=%h exp=%h", i, pc, 11'(i)); bad++; end
    end
    total++; if (stack_level !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      $display("FAIL next_state got lvl=%0d ovf=%b unf=%b exp lvl=0 ovf=0 unf=0", stack_level, ovf, unf); bad++;
    end
  endtask

  task automatic test_call_return();
    drive(3'd3, 11'h100);
    total++; if (pc !== 11'h100 || stack_level !== 4'd1 || top !== 11'h006) begin
      $display("FAIL call got pc=%h lvl=%0d top=%h exp pc=100 lvl=1 top=006", pc, stack_level, top); bad++;
    end
    drive(3'd1, '0);
    drive(3'd7, '0);
    total++; if (pc !== 11'h102 || top !== 11'h006) begin
      $display("FAIL call_body got pc=%h top=%h exp pc=102 top=006", pc, top); bad++;
    end
    drive(3'd4, '0);
    total++; if (pc !== 11'h006 || stack_level !== 4'd0 || top !== 11'h000) begin
      $display("FAIL return got pc=%h lvl=%0d top=%h exp pc=006 lvl=0 top=000", pc, stack_level, top); bad++;
    end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_lvl;
    drive(3'd2, 11'h010);
    for (int i = 0; i < 9; i++) begin
      drive(3'd3, 11'(32'h20 + i));
      exp_lvl = (i < 8) ? 4'(i + 1) : 4'd8;
      total++; if (stack_level !== exp_lvl || ovf !== (i == 8)) begin
        $display("FAIL ovf_call[%0d] got lvl=%0d ovf=%b exp lvl=%0d ovf=%b", i, stack_level, ovf, exp_lvl, (i == 8)); bad++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      drive(3'd4, '0);
      total++; if (pc !== 11'(32'h28 - k) || stack_level !== 4'(7 - k)) begin
        $display("FAIL ovf_ret[%0d] got pc=%h lvl=%0d exp pc=%h lvl=%0d", k, pc, stack_level, 11'(32'h28 - k), 4'(7 - k)); bad++;
      end
    end
    total++; if (ovf !== 1'b1) begin $display("FAIL ovf_sticky got=%b exp=1", ovf); bad++; end
    clr_err = 1'b1;
    drive(3'd0, '0);
    clr_err = 1'b0;
    total++; if (ovf !== 1'b0 || pc !== 11'h021) begin
      $display("FAIL ovf_clear got ovf=%b pc=%h exp ovf=0 pc=021", ovf, pc); bad++;
    end
  endtask

  task automatic test_underflow();
    drive(3'd4, '0);
    total++; if (pc !== 11'h000 || unf !== 1'b1 || stack_level !== 4'd0) begin
      $display("FAIL unf got pc=%h unf=%b lvl=%0d exp pc=000 unf=1 lvl=0", pc, unf, stack_level); bad++;
    end
    clr_err = 1'b1;
    drive(3'd0, '0);
    total++; if (unf !== 1'b0) begin $display("FAIL unf_clear got=%b exp=0", unf); bad++; end
    drive(3'd4, '0);
    clr_err = 1'b0;
    total++; if (unf !== 1'b1) begin $display("FAIL unf_set_wins got=%b exp=1", unf); bad++; end
  endtask

  task automatic test_stall();
    drive(3'd2, 11'h030);
    stall = 1'b1;
    clr_err = 1'b1;
    drive(3'd3, 11'h040);
    clr_err = 1'b0;
    total++; if (pc !== 11'h030 || stack_level !== 4'd0 || unf !== 1'b0) begin
      $display("FAIL stall1 got pc=%h lvl=%0d unf=%b exp pc=030 lvl=0 unf=0", pc, stack_level, unf); bad++;
    end
    drive(3'd3, 11'h040);
    total++; if (pc !== 11'h030 || stack_level !== 4'd0) begin
      $display("FAIL stall2 got pc=%h lvl=%0d exp pc=030 lvl=0", pc, stack_level); bad++;
    end
    stall = 1'b0;
    drive(3'd3, 11'h040);
    total++; if (pc !== 11'h040 || stack_level !== 4'd1 || top !== 11'h031) begin
      $display("FAIL stall_release got pc=%h lvl=%0d top=%h exp pc=040 lvl=1 top=031", pc, stack_level, top); bad++;
    end
    drive(3'd4, '0);
    total++; if (pc !== 11'h031 || stack_level !== 4'd0) begin
      $display("FAIL stall_ret got pc=%h lvl=%0d exp pc=031 lvl=0", pc, stack_level); bad++;
    end
  endtask

  task automatic test_wrap_and_async_reset();
    drive(3'd2, 11'h7FF);
    drive(3'd1, '0);
    total++; if (pc !== 11'h000) begin $display("FAIL wrap_next got=%h exp=000", pc); bad++; end
    drive(3'd2, 11'h7FF);
    drive(3'd3, 11'h050);
    total++; if (pc !== 11'h050 || top !== 11'h000 || stack_level !== 4'd1) begin
      $display("FAIL wrap_call got pc=%h top=%h lvl=%0d exp pc=050 top=000 lvl=1", pc, top, stack_level); bad++;
    end
    pc_op = 3'd3; target = 11'h123;
    #2;
    reset = 1'b0;
    #1;
    total++; if (pc !== 11'h000 || stack_level !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      $display("FAIL async_reset got pc=%h lvl=%0d ovf=%b unf=%b exp pc=000 lvl=0 flags=0", pc, stack_level, ovf, unf); bad++;
    end
    step();
    reset = 1'b1;
    pc_op = 3'd0;
    step();
    total++; if (pc !== 11'h000 || stack_level !== 4'd0 || top !== 11'h000) begin
      $display("FAIL post_reset got pc=%h lvl=%0d top=%h exp pc=000 lvl=0 top=000", pc, stack_level, top); bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_call_return();
    test_overflow();
    test_underflow();
    test_stall();
    test_wrap_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
